// File: rtl/l1c_axi_master_bridge_if.sv
// rtl/l1c_axi_master_bridge_if.sv - AXI4 channel bundle between the L1 cache bridge and memory
interface l1c_axi_master_bridge_if;
  // Read address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  // Read data channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // Write address channel
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  // Write data channel
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // Write response channel
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/l1c_axi_master_bridge.sv
// rtl/l1c_axi_master_bridge.sv - L1 cache D_req/D_wait to single-outstanding AXI4 master bridge
module l1c_axi_master_bridge #(
  parameter logic [3:0] ID_VAL     = 4'h0,
  parameter int         LINE_BEATS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        D_req,
  input  logic [31:0] D_addr,
  input  logic        D_write,
  input  logic [31:0] D_in,
  input  logic [2:0]  D_type,
  output logic [31:0] D_out,
  output logic        D_wait,
  output logic        D_beat_valid,
  output logic        D_err,
  l1c_axi_master_bridge_if.master axi
);

  localparam logic [2:0] TYPE_LINE  = 3'b011;
  localparam logic [3:0] LINE_ARLEN = 4'(LINE_BEATS - 1);
  localparam logic [7:0] LINE_CNT   = 8'(LINE_BEATS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RADDR,
    ST_RDATA,
    ST_WADDR,
    ST_WRESP,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] d_out_q, d_out_d;
  logic        beat_valid_q, beat_valid_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic        is_line;
  logic [7:0]  exp_beats;
  logic [3:0]  wstrb_c;

  // IDs are single-valued, so returned RID/BID carry no information
  logic unused_ids;
  assign unused_ids = ^{axi.rid, axi.bid};

  assign is_line   = (type_q == TYPE_LINE);
  assign exp_beats = is_line ? LINE_CNT : 8'd1;

  // Byte-lane strobe from captured access size and address offset
  always_comb begin
    wstrb_c = 4'b1111;
    case (type_q[1:0])
      2'b00:   wstrb_c = 4'b0001 << addr_q[1:0];
      2'b01:   wstrb_c = 4'b0011 << {addr_q[1], 1'b0};
      default: wstrb_c = 4'b1111;
    endcase
  end

  // Next-state, captured-request updates and AXI/cache-side outputs
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    type_d       = type_q;
    d_out_d      = d_out_q;
    beat_valid_d = 1'b0;
    err_d        = err_q;
    cnt_d        = cnt_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;

    axi.arid    = ID_VAL;
    axi.araddr  = is_line ? {addr_q[31:4], 4'b0000} : addr_q;
    axi.arlen   = is_line ? LINE_ARLEN : 4'd0;
    axi.arsize  = 3'b010;
    axi.arburst = 2'b01;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    axi.awid    = ID_VAL;
    axi.awaddr  = addr_q;
    axi.awlen   = 4'd0;
    axi.awsize  = 3'b010;
    axi.awburst = 2'b01;
    axi.awvalid = 1'b0;
    axi.wdata   = data_q << {addr_q[1:0], 3'b000};
    axi.wstrb   = wstrb_c;
    axi.wlast   = 1'b1;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;

    D_wait = (state_q != ST_DONE);

    case (state_q)
      ST_IDLE: begin
        D_wait = D_req;
        if (D_req) begin
          addr_d    = D_addr;
          data_d    = D_in;
          type_d    = D_type;
          err_d     = 1'b0;
          cnt_d     = 8'd0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (!D_write) begin
            state_d = ST_RADDR;
          end else if (D_type == TYPE_LINE) begin
            // Line writes are not supported by the cache protocol: fail without touching AXI
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WADDR;
          end
        end
      end
      ST_RADDR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        axi.rready = 1'b1;
        if (axi.rvalid) begin
          beat_valid_d = 1'b1;
          d_out_d      = axi.rdata;
          cnt_d        = cnt_q + 8'd1;
          if (axi.rresp != 2'b00) err_d = 1'b1;
          if (axi.rlast) begin
            if (cnt_d != exp_beats) err_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_WADDR: begin
        axi.awvalid = !aw_done_q;
        axi.wvalid  = !w_done_q;
        aw_done_d   = aw_done_q | (axi.awvalid & axi.awready);
        w_done_d    = w_done_q  | (axi.wvalid & axi.wready);
        if (aw_done_d && w_done_d) state_d = ST_WRESP;
      end
      ST_WRESP: begin
        axi.bready = 1'b1;
        if (axi.bvalid) begin
          if (axi.bresp != 2'b00) err_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    D_out        = d_out_q;
    D_beat_valid = beat_valid_q;
    D_err        = (state_q == ST_DONE) && err_q;
  end

  // State and captured-request registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= 32'd0;
      data_q       <= 32'd0;
      type_q       <= 3'd0;
      d_out_q      <= 32'd0;
      beat_valid_q <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= 8'd0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      type_q       <= type_d;
      d_out_q      <= d_out_d;
      beat_valid_q <= beat_valid_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

endmodule

// File: tb/tb_l1c_axi_master_bridge.sv
// tb/tb_l1c_axi_master_bridge.sv - randomized self-checking bench for l1c_axi_master_bridge
module tb_l1c_axi_master_bridge;
  localparam int LB = 4;

  logic        clk;
  logic        rst;
  logic        D_req;
  logic [31:0] D_addr;
  logic        D_write;
  logic [31:0] D_in;
  logic [2:0]  D_type;
  logic [31:0] D_out;
  logic        D_wait;
  logic        D_beat_valid;
  logic        D_err;

  int n_checks;
  int n_errors;

  l1c_axi_master_bridge_if axi ();

  l1c_axi_master_bridge #(.ID_VAL(4'h0), .LINE_BEATS(LB)) dut (
    .clk          (clk),
    .rst          (rst),
    .D_req        (D_req),
    .D_addr       (D_addr),
    .D_write      (D_write),
    .D_in         (D_in),
    .D_type       (D_type),
    .D_out        (D_out),
    .D_wait       (D_wait),
    .D_beat_valid (D_beat_valid),
    .D_err        (D_err),
    .axi          (axi.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference read: slave-side behaviour and expected bridge responses derived from the access rules
  task automatic do_read(input logic [31:0] a, input logic [2:0] t, input int ar_wait,
                         input logic [31:0] data0, input int nsent, input int bad_beat,
                         input int rst_at);
    logic [31:0] exp_araddr;
    logic [3:0]  exp_arlen;
    int          exp_beats;
    logic        exp_err;
    logic [31:0] last_d;
    exp_araddr = (t == 3'b011) ? (a & 32'hFFFF_FFF0) : a;
    exp_arlen  = (t == 3'b011) ? 4'(LB - 1) : 4'd0;
    exp_beats  = (t == 3'b011) ? LB : 1;
    exp_err    = (nsent != exp_beats);
    last_d     = 32'd0;

    D_req = 1'b1; D_write = 1'b0; D_addr = a; D_type = t; D_in = $urandom;
    #1;
    chk("rd_wait_rise", D_wait, 1);
    cyc();
    D_addr = $urandom; D_in = $urandom; D_type = 3'(($urandom_range(0, 1) == 0) ? 3'b010 : 3'b000);

    for (int k = 0; k <= ar_wait; k++) begin
      chk("arvalid", axi.arvalid, 1);
      chk("araddr", axi.araddr, exp_araddr);
      chk("arlen", axi.arlen, exp_arlen);
      chk("rd_wait", D_wait, 1);
      if (k == 0) begin
        chk("arsize", axi.arsize, 3'b010);
        chk("arburst", axi.arburst, 2'b01);
        chk("arid", axi.arid, 4'h0);
      end
      axi.arready = (k == ar_wait);
      cyc();
    end
    axi.arready = 1'b0;
    chk("arvalid_drop", axi.arvalid, 0);

    for (int b = 0; b < nsent; b++) begin
      int gap;
      if (b == rst_at) begin
        rst = 1'b1; D_req = 1'b0;
        cyc();
        rst = 1'b0;
        chk("rst_rready", axi.rready, 0);
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_dwait", D_wait, 0);
        chk("rst_beat", D_beat_valid, 0);
        chk("rst_dout", D_out, 0);
        chk("rst_derr", D_err, 0);
        D_req = 1'b1; D_write = 1'b0; D_type = 3'b010;
        #1;
        chk("rst_dwait_follow", D_wait, 1);
        D_req = 1'b0;
        cyc();
        chk("rst_no_capture", axi.arvalid, 0);
        return;
      end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        axi.rvalid = 1'b0;
        chk("rready_gap", axi.rready, 1);
        cyc();
        chk("beat_gap", D_beat_valid, 0);
      end
      axi.rvalid = 1'b1;
      axi.rdata  = data0 + 32'(b);
      axi.rlast  = (b == nsent - 1);
      axi.rresp  = (b == bad_beat) ? 2'(($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11) : 2'b00;
      if (b == bad_beat) exp_err = 1'b1;
      chk("rready", axi.rready, 1);
      cyc();
      axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
      last_d = data0 + 32'(b);
      chk("beat_pulse", D_beat_valid, 1);
      chk("dout", D_out, last_d);
    end
    chk("done_wait", D_wait, 0);
    chk("done_err", D_err, 32'(exp_err));
    D_req = 1'b0;
    cyc();
    chk("idle_wait", D_wait, 0);
    chk("idle_beat", D_beat_valid, 0);
    chk("idle_err", D_err, 0);
    chk("idle_dout_hold", D_out, last_d);
    chk("idle_arvalid", axi.arvalid, 0);
  endtask

  // Reference write: lane shift and strobe computed from byte offset and access size
  task automatic do_write(input logic [31:0] a, input logic [2:0] t, input logic [31:0] din,
                          input int aw_wait, input int w_wait, input int b_wait,
                          input logic [1:0] resp);
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        aw_done;
    logic        w_done;
    int          off;
    off       = int'(a % 4);
    exp_wdata = din << (8 * off);
    case (t)
      3'b000, 3'b100: exp_wstrb = 4'(1 << off);
      3'b001, 3'b101: exp_wstrb = 4'(3 << ((off / 2) * 2));
      default:        exp_wstrb = 4'hF;
    endcase

    D_req = 1'b1; D_write = 1'b1; D_addr = a; D_type = t; D_in = din;
    #1;
    chk("wr_wait_rise", D_wait, 1);
    cyc();
    D_addr = $urandom; D_in = $urandom;
    if (t == 3'b011) begin
      chk("linewr_wait", D_wait, 0);
      chk("linewr_err", D_err, 1);
      chk("linewr_awvalid", axi.awvalid, 0);
      chk("linewr_wvalid", axi.wvalid, 0);
      D_req = 1'b0;
      cyc();
      chk("linewr_idle", D_wait, 0);
      return;
    end
    aw_done = 1'b0; w_done = 1'b0;
    for (int i = 0; i < 12 && !(aw_done && w_done); i++) begin
      chk("awvalid", axi.awvalid, 32'(!aw_done));
      chk("wvalid", axi.wvalid, 32'(!w_done));
      chk("wr_wait", D_wait, 1);
      if (!aw_done) begin
        chk("awaddr", axi.awaddr, a);
        chk("awlen", axi.awlen, 0);
      end
      if (!w_done) begin
        chk("wdata", axi.wdata, exp_wdata);
        chk("wstrb", axi.wstrb, exp_wstrb);
        chk("wlast", axi.wlast, 1);
      end
      axi.awready = (i >= aw_wait);
      axi.wready  = (i >= w_wait);
      cyc();
      if (axi.awready) aw_done = 1'b1;
      if (axi.wready)  w_done  = 1'b1;
      axi.awready = 1'b0; axi.wready = 1'b0;
    end
    chk("aw_w_complete", 32'(aw_done && w_done), 1);
    for (int k = 0; k <= b_wait; k++) begin
      chk("bready", axi.bready, 1);
      chk("resp_awvalid", axi.awvalid, 0);
      chk("resp_wvalid", axi.wvalid, 0);
      axi.bvalid = (k == b_wait);
      axi.bresp  = resp;
      cyc();
    end
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    chk("wdone_wait", D_wait, 0);
    chk("wdone_err", D_err, 32'(resp != 2'b00));
    D_req = 1'b0;
    cyc();
    chk("widle_wait", D_wait, 0);
    chk("widle_bready", axi.bready, 0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; D_req = 1'b0; D_addr = 32'd0; D_write = 1'b0; D_in = 32'd0; D_type = 3'b010;
    axi.arready = 1'b0; axi.rid = 4'd0; axi.rdata = 32'd0; axi.rresp = 2'b00;
    axi.rlast = 1'b0; axi.rvalid = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bid = 4'd0; axi.bresp = 2'b00; axi.bvalid = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("reset_arvalid", axi.arvalid, 0);
    chk("reset_awvalid", axi.awvalid, 0);
    chk("reset_wvalid", axi.wvalid, 0);
    chk("reset_rready", axi.rready, 0);
    chk("reset_bready", axi.bready, 0);
    chk("reset_beat", D_beat_valid, 0);
    chk("reset_err", D_err, 0);
    chk("reset_dout", D_out, 0);
    chk("reset_wait", D_wait, 0);

    do_read(32'h0000_1004, 3'b010, 2, 32'hDEAD_BEEF, 1, -1, -1);
    do_read(32'h0000_2038, 3'b011, 0, 32'h0000_0001, LB, -1, -1);
    do_write(32'h0000_3003, 3'b000, 32'h0000_00AB, 1, 3, 1, 2'b00);
    do_write(32'h0000_4002, 3'b001, 32'h0000_1234, 0, 0, 0, 2'b10);
    do_read(32'h0000_5008, 3'b010, 10, 32'h1357_9BDF, 1, -1, -1);
    do_read(32'h0000_6010, 3'b011, 1, 32'hA000_0000, LB, -1, 2);
    do_write(32'h0000_7000, 3'b011, 32'h5555_5555, 0, 0, 0, 2'b00);
    do_read(32'h0000_8000, 3'b011, 0, 32'h0BAD_0000, 2, -1, -1);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        logic [2:0] t;
        int         eb;
        int         ns;
        int         bb;
        t  = 3'($urandom_range(0, 5));
        eb = (t == 3'b011) ? LB : 1;
        ns = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 5)) : eb;
        bb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, ns - 1)) : -1;
        do_read(a, t, $urandom_range(0, 3), $urandom, ns, bb, -1);
      end else begin
        logic [2:0] t;
        logic [1:0] r;
        case ($urandom_range(0, 9))
          0, 1:    t = 3'b000;
          2, 3:    t = 3'b001;
          4, 5, 6: t = 3'b010;
          7:       t = 3'b100;
          8:       t = 3'b101;
          default: t = 3'b011;
        endcase
        r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        do_write(a, t, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), r);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
